// File: rtl/uart_cmd_tx.sv
// Tile-write command transmitter: queues {col,row,char} requests and sends each one as a
// 4-byte 8N1 frame (col, row, char, EOL) on tx_o.
module uart_cmd_tx #(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  EOL_CHAR   = 8'h0A
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [6:0] col_i,
  input  logic [4:0] row_i,
  input  logic [6:0] char_i,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int unsigned BaudDiv = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW    = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntLast  = CntW'(BaudDiv - 1);
  localparam logic [PtrW:0]   FifoFull = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Request FIFO
  logic [18:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   fifo_cnt_q, fifo_cnt_d;
  logic            ready_q;
  logic            fifo_push, fifo_pop, fifo_empty;
  logic [18:0]     fifo_head;

  // Serialiser
  state_e          state_q;
  logic [CntW-1:0] baud_cnt_q;
  logic [2:0]      bit_q;
  logic [1:0]      idx_q;
  logic [18:0]     frame_q;
  logic            tx_q, tx_d;
  logic            busy_q;
  logic            baud_done;
  logic [7:0]      cur_byte;

  assign fifo_push  = valid_i & ready_q;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign baud_done  = (baud_cnt_q == CntLast);

  // Pop either from idle or at the end of the EOL stop bit, so frames run back to back.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == StIdle) begin
        fifo_pop = 1'b1;
      end else if (state_q == StStop && baud_done && idx_q == 2'd3) begin
        fifo_pop = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    unique case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q] <= {col_i, row_i, char_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      ready_q    <= 1'b1;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      fifo_cnt_q <= fifo_cnt_d;
      ready_q    <= (fifo_cnt_d != FifoFull);
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    cur_byte = {1'b0, frame_q[18:12]};
      2'd1:    cur_byte = {3'b000, frame_q[11:7]};
      2'd2:    cur_byte = {1'b0, frame_q[6:0]};
      default: cur_byte = EOL_CHAR;
    endcase
  end

  always_comb begin
    case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

  // tx_q and busy_q trail state_q by one cycle, so both line up with the line level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_q      <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= (state_q != StIdle) || !fifo_empty || fifo_push;
      case (state_q)
        StIdle: begin
          baud_cnt_q <= '0;
          if (fifo_pop) begin
            frame_q <= fifo_head;
            idx_q   <= 2'd0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            bit_q      <= 3'd0;
            state_q    <= StData;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (idx_q != 2'd3) begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StStart;
            end else if (fifo_pop) begin
              frame_q <= fifo_head;
              idx_q   <= 2'd0;
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o = ready_q;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;

endmodule
